// File: rtl/hi_1575_bus_responder_if.sv
// Word stream interface between the HI-1575 responder and its codec side.
//   rx_*  : received 1553 words flowing into the responder (valid/ready)
//   tx_*  : host-written words flowing out of the responder (valid/ready)
// Modports:
//   master : codec / sink side (drives rx words, accepts tx words)
//   slave  : responder side
interface hi_1575_bus_responder_if;
  logic [15:0] rx_data_in;
  logic        rx_cmd_in;
  logic        rx_ch_in;
  logic        rx_valid_in;
  logic        rx_ready_out;
  logic [15:0] tx_data_out;
  logic        tx_cmd_out;
  logic        tx_ch_out;
  logic        tx_valid_out;
  logic        tx_ready_in;

  modport master (
    output rx_data_in, rx_cmd_in, rx_ch_in, rx_valid_in, tx_ready_in,
    input  rx_ready_out, tx_data_out, tx_cmd_out, tx_ch_out, tx_valid_out
  );

  modport slave (
    input  rx_data_in, rx_cmd_in, rx_ch_in, rx_valid_in, tx_ready_in,
    output rx_ready_out, tx_data_out, tx_cmd_out, tx_ch_out, tx_valid_out
  );
endinterface

// File: rtl/hi_1575_bus_responder.sv
// HI-1575 host parallel port responder.
// Presents received 1553 words to a host controller through pin_rcva/pin_rcvb
// and strobed reads on pin_d/pin_sync; forwards host strobed writes as words
// on a valid/ready sink.
// Ports:
//   clock_100, reset_b          : clock, async active-low reset
//   pin_rcva / pin_rcvb         : word pending on bus A / bus B
//   pin_reg, pin_r_w, pin_strb_n, pin_mr, pin_cha_chb : host control pins
//   pin_sync, pin_d             : tri-state host data (driven on reads)
//   bus (slave)                 : rx word source and tx word sink
//   tx_overrun, rd_mismatch     : sticky error flags
// Build option: define HI1575_RX_FIFO_EN to queue rx words in a FIFO_DEPTH
// deep FIFO ahead of the holding register.
//
// state   | meaning
// RX_IDLE | no word pending, ready for the next rx word
// RX_PEND | word in holding register, pin_rcvX high
// RX_READ | host read strobe in progress on the pending word
// RX_GAP  | word consumed, pin_rcvX held low for RCV_GAP clocks
module hi_1575_bus_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int RCV_GAP     = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clock_100,
  input  logic       reset_b,
  output logic       pin_rcva,
  output logic       pin_rcvb,
  input  logic       pin_reg,
  input  logic       pin_r_w,
  input  logic       pin_strb_n,
  input  logic       pin_mr,
  input  logic       pin_cha_chb,
  inout  wire        pin_sync,
  inout  wire [15:0] pin_d,
  hi_1575_bus_responder_if.slave bus,
  output logic       tx_overrun,
  output logic       rd_mismatch
);

  typedef enum logic [1:0] {RX_IDLE, RX_PEND, RX_READ, RX_GAP} rx_state_t;

  localparam int SW = 22;
  localparam int GW = $clog2(RCV_GAP + 1);
  // strobe bit resets high so reset release does not look like a strobe rise
  localparam logic [SW-1:0] SYNC_RST = {2'b00, 1'b1, 19'd0};

  // bits: [21] reg, [20] r_w, [19] strb_n, [18] mr, [17] cha_chb, [16] sync, [15:0] d
  logic [SW-1:0] sync_q [SYNC_STAGES];
  logic [SW-1:0] sync_s;
  logic          reg_s, r_w_s, strb_s, mr_s, cha_s, syn_s;
  logic [15:0]   d_s;

  logic strb_d, rw_lat, reg_lat;
  logic strb_fall, strb_rise, wr_rise, rd_start;

  rx_state_t     state, state_nxt;
  logic [GW-1:0] gap_cnt;
  logic          load_hold, word_avail, word_queued, rx_ready;
  logic [17:0]   src_word;

  logic [15:0] hold_data;
  logic        hold_cmd, hold_ch;
  logic        drive_en;

  logic [15:0] tx_data;
  logic        tx_cmd, tx_ch, tx_valid;

  always_ff @(posedge clock_100 or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
    end else begin
      sync_q[0] <= {pin_reg, pin_r_w, pin_strb_n, pin_mr, pin_cha_chb, pin_sync, pin_d};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign reg_s  = sync_s[21];
  assign r_w_s  = sync_s[20];
  assign strb_s = sync_s[19];
  assign mr_s   = sync_s[18];
  assign cha_s  = sync_s[17];
  assign syn_s  = sync_s[16];
  assign d_s    = sync_s[15:0];

  // Direction and register select are frozen at the strobe fall so a strobe
  // can never act as both a read and a write.
  always_ff @(posedge clock_100 or negedge reset_b) begin
    if (!reset_b) begin
      strb_d  <= 1'b1;
      rw_lat  <= 1'b1;
      reg_lat <= 1'b0;
    end else begin
      strb_d <= strb_s;
      if (strb_fall) begin
        rw_lat  <= r_w_s;
        reg_lat <= reg_s;
      end
    end
  end

  assign strb_fall = strb_d & ~strb_s;
  assign strb_rise = ~strb_d & strb_s;
  assign wr_rise   = strb_rise & ~rw_lat & ~reg_lat;
  assign rd_start  = strb_fall & r_w_s & ~reg_s;

`ifdef HI1575_RX_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  logic [17:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_push, fifo_full, fifo_empty;

  assign fifo_full   = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty  = (fifo_cnt == '0);
  assign rx_ready    = reset_b & ~mr_s & ~fifo_full;
  assign fifo_push   = bus.rx_valid_in & rx_ready;
  assign src_word    = fifo_mem[rd_ptr];
  assign word_avail  = ~fifo_empty;
  assign word_queued = ~fifo_empty;

  always_ff @(posedge clock_100) begin
    if (fifo_push) fifo_mem[wr_ptr] <= {bus.rx_ch_in, bus.rx_cmd_in, bus.rx_data_in};
  end

  always_ff @(posedge clock_100 or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (mr_s) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + AW'(1);
      if (load_hold) rd_ptr <= rd_ptr + AW'(1);
      if (fifo_push && !load_hold)      fifo_cnt <= fifo_cnt + (AW+1)'(1);
      else if (!fifo_push && load_hold) fifo_cnt <= fifo_cnt - (AW+1)'(1);
    end
  end
`else
  logic [31:0] unused_fifo_depth;
  assign unused_fifo_depth = 32'(FIFO_DEPTH);
  assign rx_ready    = reset_b & ~mr_s & (state == RX_IDLE);
  assign src_word    = {bus.rx_ch_in, bus.rx_cmd_in, bus.rx_data_in};
  assign word_avail  = bus.rx_valid_in & rx_ready;
  assign word_queued = 1'b0;
`endif

  always_ff @(posedge clock_100 or negedge reset_b) begin
    if (!reset_b) begin
      state   <= RX_IDLE;
      gap_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == RX_GAP && state != RX_GAP) gap_cnt <= GW'(RCV_GAP - 1);
      else if (gap_cnt != '0)                     gap_cnt <= gap_cnt - GW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE: if (word_avail) state_nxt = RX_PEND;
      RX_PEND: if (rd_start) state_nxt = RX_READ;
      RX_READ: if (strb_rise) state_nxt = RX_GAP;
      RX_GAP:  if (gap_cnt == '0) state_nxt = word_queued ? RX_PEND : RX_IDLE;
      default: state_nxt = RX_IDLE;
    endcase
    if (mr_s) state_nxt = RX_IDLE;
  end

  always_comb begin
    pin_rcva = 1'b0;
    pin_rcvb = 1'b0;
    if (state == RX_PEND || state == RX_READ) begin
      pin_rcva = ~hold_ch;
      pin_rcvb = hold_ch;
    end
  end

  assign bus.rx_ready_out = rx_ready;
  assign load_hold = (state_nxt == RX_PEND) && (state != RX_PEND);

  always_ff @(posedge clock_100 or negedge reset_b) begin
    if (!reset_b) begin
      hold_data <= '0;
      hold_cmd  <= 1'b0;
      hold_ch   <= 1'b0;
    end else if (mr_s) begin
      hold_data <= '0;
      hold_cmd  <= 1'b0;
      hold_ch   <= 1'b0;
    end else if (load_hold) begin
      {hold_ch, hold_cmd, hold_data} <= src_word;
    end
  end

  // Drive follows the raw pins so data is valid within the host's strobe.
  assign drive_en = reset_b & ~mr_s & ~pin_strb_n & pin_r_w & ~pin_reg;
  assign pin_d    = drive_en ? hold_data : 16'hzzzz;
  assign pin_sync = drive_en ? hold_cmd : 1'bz;

  always_ff @(posedge clock_100 or negedge reset_b) begin
    if (!reset_b) begin
      rd_mismatch <= 1'b0;
    end else if (mr_s) begin
      rd_mismatch <= 1'b0;
    end else if (state == RX_READ && strb_rise && cha_s != hold_ch) begin
      rd_mismatch <= 1'b1;
    end
  end

  always_ff @(posedge clock_100 or negedge reset_b) begin
    if (!reset_b) begin
      tx_data    <= '0;
      tx_cmd     <= 1'b0;
      tx_ch      <= 1'b0;
      tx_valid   <= 1'b0;
      tx_overrun <= 1'b0;
    end else if (mr_s) begin
      tx_data    <= '0;
      tx_cmd     <= 1'b0;
      tx_ch      <= 1'b0;
      tx_valid   <= 1'b0;
      tx_overrun <= 1'b0;
    end else begin
      if (tx_valid && bus.tx_ready_in) tx_valid <= 1'b0;
      if (wr_rise) begin
        // a word leaving this very clock frees the register for the new one
        if (tx_valid && !bus.tx_ready_in) begin
          tx_overrun <= 1'b1;
        end else begin
          tx_data  <= d_s;
          tx_cmd   <= syn_s;
          tx_ch    <= cha_s;
          tx_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.tx_data_out  = tx_data;
  assign bus.tx_cmd_out   = tx_cmd;
  assign bus.tx_ch_out    = tx_ch;
  assign bus.tx_valid_out = tx_valid;

endmodule

// File: tb/tb_hi_1575_bus_responder.sv
// Self-checking bench for hi_1575_bus_responder: directed host reads/writes
// and rx words; expected tx words and read data go into queues that a
// negedge monitor pops when the DUT presents them.
module tb_hi_1575_bus_responder;
  localparam int RCV_GAP = 4;

  logic clock_100;
  logic reset_b;
  logic pin_rcva, pin_rcvb;
  logic pin_reg, pin_r_w, pin_strb_n, pin_mr, pin_cha_chb;
  wire        pin_sync;
  wire [15:0] pin_d;
  logic        tx_overrun, rd_mismatch;
  logic        drv_en;
  logic [15:0] drv_d;
  logic        drv_sync;
  logic        rd_pulse;

  int checks = 0;
  int errors = 0;

  logic [17:0] tx_q [$];
  logic [16:0] rd_q [$];
  logic [17:0] tx_exp;
  logic [16:0] rd_exp;

  hi_1575_bus_responder_if bus ();

  assign pin_d    = drv_en ? drv_d : 16'hzzzz;
  assign pin_sync = drv_en ? drv_sync : 1'bz;

  hi_1575_bus_responder #(.SYNC_STAGES(2), .RCV_GAP(RCV_GAP), .FIFO_DEPTH(4)) dut (
    .clock_100   (clock_100),
    .reset_b     (reset_b),
    .pin_rcva    (pin_rcva),
    .pin_rcvb    (pin_rcvb),
    .pin_reg     (pin_reg),
    .pin_r_w     (pin_r_w),
    .pin_strb_n  (pin_strb_n),
    .pin_mr      (pin_mr),
    .pin_cha_chb (pin_cha_chb),
    .pin_sync    (pin_sync),
    .pin_d       (pin_d),
    .bus         (bus),
    .tx_overrun  (tx_overrun),
    .rd_mismatch (rd_mismatch)
  );

  initial clock_100 = 1'b0;
  always #5 clock_100 = ~clock_100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clock_100) begin
    if (bus.tx_valid_out && bus.tx_ready_in) begin
      checks++;
      if (tx_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected actual=%0h required=none",
                 {bus.tx_ch_out, bus.tx_cmd_out, bus.tx_data_out});
      end else begin
        tx_exp = tx_q.pop_front();
        if ({bus.tx_ch_out, bus.tx_cmd_out, bus.tx_data_out} !== tx_exp) begin
          errors++;
          $display("FAIL tx_word actual=%0h required=%0h",
                   {bus.tx_ch_out, bus.tx_cmd_out, bus.tx_data_out}, tx_exp);
        end
      end
    end
    if (rd_pulse) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected actual=%0h required=none", {pin_sync, pin_d});
      end else begin
        rd_exp = rd_q.pop_front();
        if ({pin_sync, pin_d} !== rd_exp) begin
          errors++;
          $display("FAIL rd_word actual=%0h required=%0h", {pin_sync, pin_d}, rd_exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock_100);
      #1;
    end
  endtask

  task automatic rx_send(input logic [15:0] d, input logic cmd, input logic ch);
    bool_accept : begin
      bus.rx_data_in  = d;
      bus.rx_cmd_in   = cmd;
      bus.rx_ch_in    = ch;
      bus.rx_valid_in = 1'b1;
      for (int i = 0; i < 50; i++) begin
        if (bus.rx_ready_out) begin
          tick(1);
          bus.rx_valid_in = 1'b0;
          disable bool_accept;
        end
        tick(1);
      end
      bus.rx_valid_in = 1'b0;
      checks++;
      errors++;
      $display("FAIL rx_accept_timeout actual=not_ready required=ready");
    end
  endtask

  task automatic host_read(input logic ch, output int drop_clk, output logic pend_at_rise);
    pin_r_w     = 1'b1;
    pin_cha_chb = ch;
    tick(1);
    pin_strb_n = 1'b0;
    tick(4);
    rd_pulse = 1'b1;
    tick(1);
    rd_pulse     = 1'b0;
    pend_at_rise = pin_rcva | pin_rcvb;
    pin_strb_n   = 1'b1;
    drop_clk     = 99;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (!pin_rcva && !pin_rcvb) begin
        drop_clk = i;
        break;
      end
    end
  endtask

  task automatic host_write(input logic [15:0] d, input logic s, input logic ch, input logic pulse);
    pin_r_w     = 1'b0;
    pin_cha_chb = ch;
    drv_d       = d;
    drv_sync    = s;
    drv_en      = 1'b1;
    tick(1);
    pin_strb_n = 1'b0;
    tick(3);
    pin_strb_n = 1'b1;
    tick(2);
    if (pulse) bus.tx_ready_in = 1'b1;
    tick(1);
    if (pulse) bus.tx_ready_in = 1'b0;
    tick(1);
    drv_en  = 1'b0;
    pin_r_w = 1'b1;
  endtask

  task automatic tx_release();
    bus.tx_ready_in = 1'b1;
    tick(1);
    bus.tx_ready_in = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int   drop;
    logic pend;
    int   gap;
    reset_b = 1'b0;
    pin_reg = 1'b0; pin_r_w = 1'b1; pin_strb_n = 1'b1; pin_mr = 1'b0; pin_cha_chb = 1'b0;
    drv_en = 1'b0; drv_d = '0; drv_sync = 1'b0; rd_pulse = 1'b0;
    bus.rx_data_in = '0; bus.rx_cmd_in = 1'b0; bus.rx_ch_in = 1'b0;
    bus.rx_valid_in = 1'b0; bus.tx_ready_in = 1'b0;

    #23;
    chk("rst_rcv", {pin_rcva, pin_rcvb}, 0);
    chk("rst_rx_ready", bus.rx_ready_out, 0);
    chk("rst_tx_valid", bus.tx_valid_out, 0);
    chk("rst_flags", {tx_overrun, rd_mismatch}, 0);
    reset_b = 1'b1;
    tick(3);
    chk("idle_rx_ready", bus.rx_ready_out, 1);

    // T1: command word on A, read back, rcva drop latency
    rx_send(16'hA5C3, 1'b1, 1'b0);
    chk("t1_rcv", {pin_rcva, pin_rcvb}, 2'b10);
`ifndef HI1575_RX_FIFO_EN
    chk("t1_pend_not_ready", bus.rx_ready_out, 0);
`endif
    rd_q.push_back({1'b1, 16'hA5C3});
    host_read(1'b0, drop, pend);
    chk("t1_pend_at_rise", pend, 1);
    chk("t1_drop_le3", drop <= 3, 1);
    chk("t1_no_mismatch", rd_mismatch, 0);
    tick(8);
    chk("t1_back_idle", bus.rx_ready_out, 1);
    // read while idle returns the last word and nothing else
    rd_q.push_back({1'b1, 16'hA5C3});
    host_read(1'b1, drop, pend);
    chk("idle_read_rcv", {pin_rcva, pin_rcvb}, 0);
    chk("idle_read_no_mismatch", rd_mismatch, 0);

    // T2: host write forwarded, held until ready
    tx_q.push_back({1'b1, 1'b0, 16'h1234});
    host_write(16'h1234, 1'b0, 1'b1, 1'b0);
    chk("t2_valid", bus.tx_valid_out, 1);
    tick(5);
    chk("t2_valid_held", bus.tx_valid_out, 1);
    tx_release();
    chk("t2_valid_drop", bus.tx_valid_out, 0);

    // write captured in the same clock the pending word is accepted
    tx_q.push_back({1'b0, 1'b1, 16'h0005});
    host_write(16'h0005, 1'b1, 1'b0, 1'b0);
    tx_q.push_back({1'b1, 1'b0, 16'h0006});
    host_write(16'h0006, 1'b0, 1'b1, 1'b1);
    chk("same_clk_valid", bus.tx_valid_out, 1);
    chk("same_clk_no_overrun", tx_overrun, 0);
    tx_release();

    // T3: overrun keeps the old word
    tx_q.push_back({1'b0, 1'b0, 16'h0001});
    host_write(16'h0001, 1'b0, 1'b0, 1'b0);
    host_write(16'h0002, 1'b0, 1'b0, 1'b0);
    chk("t3_overrun", tx_overrun, 1);
    chk("t3_valid", bus.tx_valid_out, 1);
    tx_release();
    chk("t3_overrun_sticky", tx_overrun, 1);

    // T4: word on B read with channel A selected
    rx_send(16'h00FF, 1'b0, 1'b1);
    chk("t4_rcv", {pin_rcva, pin_rcvb}, 2'b01);
    rd_q.push_back({1'b0, 16'h00FF});
    host_read(1'b0, drop, pend);
    chk("t4_pend_at_rise", pend, 1);
    chk("t4_drop_le3", drop <= 3, 1);
    chk("t4_mismatch", rd_mismatch, 1);
    tick(8);

    // T5: master reset while pending with tx word queued
    rx_send(16'hBEEF, 1'b1, 1'b0);
    host_write(16'h7777, 1'b1, 1'b0, 1'b0);
    chk("t5_pre_rcv", {pin_rcva, pin_rcvb}, 2'b10);
    chk("t5_pre_valid", bus.tx_valid_out, 1);
    pin_mr = 1'b1;
    tick(3);
    chk("t5_mr_not_ready", bus.rx_ready_out, 0);
    tick(2);
    pin_mr = 1'b0;
    tick(4);
    chk("t5_rcv", {pin_rcva, pin_rcvb}, 0);
    chk("t5_tx_valid", bus.tx_valid_out, 0);
    chk("t5_flags", {tx_overrun, rd_mismatch}, 0);
    chk("t5_rx_ready", bus.rx_ready_out, 1);
    rd_q.push_back({1'b0, 16'h0000});
    host_read(1'b1, drop, pend);

`ifdef HI1575_RX_FIFO_EN
    // T6: queued words come out in order with a full gap between them
    for (int i = 1; i <= 5; i++) rx_send(16'h1000 + 16'(i), 1'(i), 1'b0);
    chk("t6_full", bus.rx_ready_out, 0);
    for (int i = 1; i <= 5; i++) begin
      rd_q.push_back({1'(i), 16'h1000 + 16'(i)});
      host_read(1'b0, drop, pend);
      chk("t6_drop_le3", drop <= 3, 1);
      if (i < 5) begin
        gap = 99;
        for (int c = 1; c <= 30; c++) begin
          tick(1);
          if (pin_rcva) begin
            gap = c;
            break;
          end
        end
        chk("t6_gap", (gap >= RCV_GAP) && (gap != 99), 1);
      end
    end
`endif

    tick(4);
    chk("tx_q_drained", tx_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
